// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the CPU nibble-bus responder: FSM state encoding,
// I/O page offsets and the default I/O page base address.
// No ports; imported by mem_bus_responder and nibble_ram.
package mem_bus_responder_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [10:0] IO_BASE_DEFAULT = 11'h7F0;

  localparam logic [3:0] IO_OUT  = 4'd0;
  localparam logic [3:0] IO_IN   = 4'd1;
  localparam logic [3:0] IO_TMR0 = 4'd2;
  localparam logic [3:0] IO_TMR1 = 4'd3;
  localparam logic [3:0] IO_TMR2 = 4'd4;

endpackage

// File: rtl/mem_bus_responder_nibble_ram.sv
// nibble_ram: 2^AW x 4-bit storage, asynchronous read, one synchronous write
// port, asynchronous clear of every location.
// Ports: clk, rst_n, we/waddr/wdata (write), raddr/rdata (combinational read).
module nibble_ram
  import mem_bus_responder_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);

  localparam int DEPTH = 1 << AW;

  logic [3:0] mem_q [DEPTH];
  logic [3:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'h0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: target end of the CPU nibble bus. Serves an aliased
// nibble RAM plus a 16-nibble I/O page, and owns the serial program loader
// that holds the CPU in reset (cpu_rst_n) while code is streamed in.
// Ports: clk/rst_n; bus_addr, bus_data_rw, bus_wdata, bus_rdata (CPU bus);
// cpu_rst_n; load_en/load_valid/load_data/load_ready (loader);
// out_port (output latch), in_port (async input).
// Optional feature macro RESPONDER_TIMER_EN: 12-bit RUN-cycle timer with
// live low nibble at IO+2 and an 8-bit snapshot readable at IO+3/IO+4.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int          RAM_AW  = 6,
  parameter logic [10:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] bus_addr,
  input  logic        bus_data_rw,
  input  logic [3:0]  bus_wdata,
  output logic [3:0]  bus_rdata,
  output logic        cpu_rst_n,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [3:0]  load_data,
  output logic        load_ready,
  output logic [3:0]  out_port,
  input  logic [3:0]  in_port
);

  state_t            state_q, state_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              rw_q, rw_d;
  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic [3:0]        out_port_q, out_port_d;
  logic [3:0]        in_s1_q, in_s2_q;

  logic              is_io;
  logic [3:0]        io_off;
  logic              load_fire;
  logic              bus_we;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [3:0]        ram_wdata;
  logic [3:0]        ram_rdata;

  assign is_io  = (bus_addr[10:4] == IO_BASE[10:4]);
  assign io_off = bus_addr[3:0];

  // FSM next state; cpu_rst_n is registered from next state so the CPU leaves
  // reset on the same edge the FSM enters RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD:  state_d = load_en ? S_LOAD : S_RUN;
      S_RUN:   if (load_en) state_d = S_LOAD;
      S_LOAD:  if (!load_en) state_d = S_HOLD;
      default: state_d = S_HOLD;
    endcase
    cpu_rst_n_d = (state_d == S_RUN);
  end

  assign load_ready = (state_q == S_LOAD);
  assign load_fire  = load_valid & load_ready;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign out_port   = out_port_q;

  // The CPU presents stale data on the first rw=1 cycle, so a store only
  // commits once rw has been high for a previous edge as well.
  assign rw_d   = (state_q == S_RUN) & bus_data_rw;
  assign bus_we = (state_q == S_RUN) & bus_data_rw & rw_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q != S_LOAD && state_d == S_LOAD) ptr_d = '0;
    else if (load_fire)                         ptr_d = ptr_q + 1'b1;
  end

  always_comb begin
    out_port_d = out_port_q;
    if (bus_we && is_io && io_off == IO_OUT) out_port_d = bus_wdata;
  end

  // Loader and bus writes are mutually exclusive by state (LOAD vs RUN).
  assign ram_we    = load_fire | (bus_we & ~is_io);
  assign ram_waddr = load_fire ? ptr_q     : bus_addr[RAM_AW-1:0];
  assign ram_wdata = load_fire ? load_data : bus_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      cpu_rst_n_q <= 1'b0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      out_port_q  <= 4'h0;
      in_s1_q     <= 4'h0;
      in_s2_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      out_port_q  <= out_port_d;
      in_s1_q     <= in_port;
      in_s2_q     <= in_s1_q;
    end
  end

`ifdef RESPONDER_TIMER_EN
  logic [11:0] tmr_q, tmr_d;
  logic [7:0]  snap_q, snap_d;

  always_comb begin
    tmr_d = tmr_q;
    if (state_q != S_RUN && state_d == S_RUN) tmr_d = 12'h000;
    else if (state_q == S_RUN)                tmr_d = tmr_q + 12'd1;
    snap_d = snap_q;
    if (is_io && io_off == IO_TMR0 && !bus_data_rw) snap_d = tmr_q[11:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= 12'h000;
      snap_q <= 8'h00;
    end else begin
      tmr_q  <= tmr_d;
      snap_q <= snap_d;
    end
  end
`endif

  always_comb begin
    bus_rdata = ram_rdata;
    if (is_io) begin
      case (io_off)
        IO_OUT:  bus_rdata = out_port_q;
        IO_IN:   bus_rdata = in_s2_q;
`ifdef RESPONDER_TIMER_EN
        IO_TMR0: bus_rdata = tmr_q[3:0];
        IO_TMR1: bus_rdata = snap_q[3:0];
        IO_TMR2: bus_rdata = snap_q[7:4];
`endif
        default: bus_rdata = 4'h0;
      endcase
    end
  end

  nibble_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (bus_addr[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Testbench for mem_bus_responder: two instances (RAM_AW=6 and RAM_AW=2)
// share all inputs; stimulus pushes expected values into a queue that a
// negedge monitor pops and compares.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] bus_addr;
    logic        bus_data_rw;
    logic [3:0]  bus_wdata;
    logic        load_en, load_valid;
    logic [3:0]  load_data;
    logic [3:0]  in_port;

    logic [3:0]  rdata1, rdata2, out_port1, out_port2;
    logic        cpu_rst_n1, cpu_rst_n2, load_ready1, load_ready2;

    always #5 clk = ~clk;

    mem_bus_responder #(.RAM_AW(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_data_rw(bus_data_rw),
        .bus_wdata(bus_wdata), .bus_rdata(rdata1), .cpu_rst_n(cpu_rst_n1),
        .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready1), .out_port(out_port1), .in_port(in_port)
    );

    mem_bus_responder #(.RAM_AW(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_data_rw(bus_data_rw),
        .bus_wdata(bus_wdata), .bus_rdata(rdata2), .cpu_rst_n(cpu_rst_n2),
        .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready2), .out_port(out_port2), .in_port(in_port)
    );

    // Scoreboard: selector 0=rdata(AW6) 1=rdata(AW2) 2=out_port 3=cpu_rst_n 4=load_ready
    int         sel_q[$];
    logic [3:0] exp_q[$];
    string      name_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic       done        = 1'b0;

    task automatic expect4(input int sel, input logic [3:0] e, input string n);
        sel_q.push_back(sel);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    always @(negedge clk) begin
        int         s;
        logic [3:0] e, a;
        string      n;
        while (sel_q.size() > 0) begin
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            case (s)
                0:       a = rdata1;
                1:       a = rdata2;
                2:       a = out_port1;
                3:       a = {3'b000, cpu_rst_n1};
                default: a = {3'b000, load_ready1};
            endcase
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", n, a, e);
            end
        end
    end

    initial begin
        #1_000_000;
        if (!done) begin
            miscompares++;
            $display("FAIL watchdog: test sequence did not complete in time");
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    task automatic check_reset_state(input string n);
        vectors++;
        if (cpu_rst_n1 !== 1'b0 || load_ready1 !== 1'b0 || out_port1 !== 4'h0 ||
            rdata1 !== 4'h0 || rdata2 !== 4'h0 ||
            cpu_rst_n2 !== 1'b0 || load_ready2 !== 1'b0 || out_port2 !== 4'h0) begin
            miscompares++;
            $display("FAIL %s: cpu_rst_n=%b load_ready=%b out_port=%h rdata=%h/%h",
                     n, cpu_rst_n1, load_ready1, out_port1, rdata1, rdata2);
        end
    endtask

    task automatic wait_cpu_run(input int max_cycles, input string n);
        int k;
        k = 0;
        while (cpu_rst_n1 !== 1'b1 && k < max_cycles) begin
            @(posedge clk);
            #1;
            k++;
        end
        vectors++;
        if (cpu_rst_n1 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: cpu_rst_n not released within %0d cycles", n, max_cycles);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int sel, input logic [10:0] a, input logic [3:0] e, input string n);
        bus_addr = a;
        expect4(sel, e, n);
        tick();
    endtask

    task automatic bus_write(input logic [10:0] a, input logic [3:0] d);
        bus_addr    = a;
        bus_wdata   = d;
        bus_data_rw = 1'b1;
        tick();
        tick();
        bus_data_rw = 1'b0;
    endtask

    logic [3:0] t_live, t_lo, t_hi;

    initial begin
        rst_n = 1'b0; bus_addr = '0; bus_data_rw = 1'b0; bus_wdata = 4'h0;
        load_en = 1'b0; load_valid = 1'b0; load_data = 4'h0; in_port = 4'h0;
`ifdef RESPONDER_TIMER_EN
        t_live = 4'h3; t_lo = 4'h2; t_hi = 4'h1;
`else
        t_live = 4'h0; t_lo = 4'h0; t_hi = 4'h0;
`endif

        // Reset state
        tick();
        check_reset_state("reset_state");
        expect4(3, 4'h0, "rst_cpu_rst_n");
        expect4(4, 4'h0, "rst_load_ready");
        expect4(2, 4'h0, "rst_out_port");
        expect4(0, 4'h0, "rst_ram0");
        tick();

        // 1: program load 1,2,3,4
        load_en = 1'b1;
        rst_n   = 1'b1;
        tick();
        expect4(4, 4'h1, "load_ready_in_load");
        for (int i = 1; i <= 4; i++) begin
            expect4(3, 4'h0, "cpu_rst_n_during_load");
            load_valid = 1'b1;
            load_data  = 4'(i);
            tick();
        end
        load_valid = 1'b0;
        load_en    = 1'b0;
        expect4(3, 4'h0, "cpu_rst_n_load_end");
        tick();
        expect4(3, 4'h0, "cpu_rst_n_1st_edge");
        expect4(4, 4'h0, "load_ready_hold");
        tick();
        expect4(3, 4'h1, "cpu_rst_n_2nd_edge");
        for (int i = 0; i < 4; i++) rd(0, 11'(i), 4'(i + 1), "load_ram");

        // 3: store timing
        bus_addr = 11'h005; bus_wdata = 4'hF; bus_data_rw = 1'b1;
        tick();
        expect4(0, 4'h0, "store_first_edge_skipped");
        bus_wdata = 4'h9;
        tick();
        bus_data_rw = 1'b0;
        rd(0, 11'h045, 4'h9, "store_alias_aw6");
        rd(1, 11'h045, 4'h9, "store_alias_aw2");

        // 4: I/O page
        bus_write(11'h7F0, 4'h6);
        expect4(2, 4'h6, "out_port_write");
        rd(0, 11'h7F0, 4'h6, "out_port_readback");
        in_port = 4'h3;
        rd(0, 11'h7F1, 4'h0, "in_sync_0_edges");
        rd(0, 11'h7F1, 4'h0, "in_sync_1_edge");
        rd(0, 11'h7F1, 4'h3, "in_sync_2_edges");
        bus_write(11'h7F1, 4'hA);
        rd(0, 11'h031, 4'h0, "io_write_no_ram");
        rd(0, 11'h7F1, 4'h3, "io_in_unwritten");
        expect4(2, 4'h6, "out_port_kept");
        rd(0, 11'h7FF, 4'h0, "io_unmapped");

        // 2 + 5: reload with wrap, then timer
        load_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 4'(4'hA + i);
            tick();
        end
        load_valid = 1'b0;
        load_en    = 1'b0;
        tick();
        tick();
        repeat (12'h123) tick();
        rd(0, 11'h7F2, t_live, "timer_live");
        rd(0, 11'h7F3, t_lo,   "timer_snap_lo");
        rd(0, 11'h7F4, t_hi,   "timer_snap_hi");
        rd(1, 11'h000, 4'hE, "wrap_ram0");
        rd(1, 11'h001, 4'hB, "wrap_ram1");
        rd(1, 11'h002, 4'hC, "wrap_ram2");
        rd(1, 11'h003, 4'hD, "wrap_ram3");
        rd(0, 11'h000, 4'hA, "nowrap_ram0");
        rd(0, 11'h004, 4'hE, "nowrap_ram4");

        // 6: async reset mid-load
        load_en = 1'b1;
        tick();
        load_valid = 1'b1; load_data = 4'h7; tick();
        load_data = 4'h8; tick();
        load_valid = 1'b0;
        rd(0, 11'h001, 4'h8, "preload_ram1");
        #1 rst_n = 1'b0;
        #1 check_reset_state("areset_state");
        expect4(0, 4'h0, "areset_ram1");
        expect4(1, 4'h0, "areset_ram1_aw2");
        expect4(3, 4'h0, "areset_cpu_rst_n");
        expect4(4, 4'h0, "areset_load_ready");
        expect4(2, 4'h0, "areset_out_port");
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        expect4(4, 4'h1, "reload_ready");
        load_valid = 1'b1; load_data = 4'h5; tick();
        load_valid = 1'b0;
        rd(0, 11'h000, 4'h5, "reload_ptr0");
        rd(0, 11'h001, 4'h0, "reload_ram1_cleared");
        load_en = 1'b0;
        tick();
        tick();
        expect4(3, 4'h1, "run_after_reload");
        wait_cpu_run(4, "run_after_reload_wait");
        tick();
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
